execute_pipe: RTL and testbench
===============================

Name: execute_pipe

Overview:
Registered, parametrised successor to the combinational LEGv8 execute stage. It computes the ALU result, zero flag and branch target. Results are held in an output register with a valid/ready handshake, so the stage can sit between ID/EX and EX/MEM with back-pressure. It adds LSL/LSR, a pipeline flush, and an optional iterative multi-cycle MUL.

Parameters:
WIDTH, 64, datapath width in bits (power of 2, ≥16)
MUL_BITS, 1, multiplier bits retired per cycle in MUL state (divides WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input operation valid
in_ready  out  1  stage can accept an operation this cycle
cur_pc  in  WIDTH  PC of the instruction
read_data1  in  WIDTH  register operand A
read_data2  in  WIDTH  register operand B
sign_extended_output  in  WIDTH  sign-extended immediate / branch offset (words)
alu_op  in  2  00 DTYPE, 01 CBZ, 10 RTYPE, 11 B
alu_src  in  1  1: operand B = sign_extended_output; 0: read_data2
opcode  in  11  instruction opcode for RTYPE decode
flush  in  1  synchronous kill of in-flight and held results
out_valid  out  1  result registers valid
out_ready  in  1  downstream accepts result
branch_target  out  WIDTH  registered cur_pc + (sign_extended_output << 2), modulo 2^WIDTH
alu_result  out  WIDTH  registered ALU result
zero  out  1  registered (alu_result == 0)
busy  out  1  high while in MUL state

Behaviour:
- Reset (async, rst_n=0): out_valid=0, busy=0, branch_target=0, alu_result=0, zero=0, state=IDLE, multiplier accumulator cleared.
- Accept: in_valid && in_ready at a rising edge. in_ready = (state==IDLE) && !flush && (!out_valid || out_ready).
- Operand B = alu_src ? sign_extended_output : read_data2.
- ALU function:
  - DTYPE: A+B.
  - CBZ: pass read_data2.
  - B: result 0.
  - RTYPE decoded by opcode:
    - ADD 10001011000: A+B
    - SUB 11001011000: A−B
    - AND 10001010000: A&B
    - ORR 10101010000: A|B
    - LSL 11010011011: A << B[log2(WIDTH)-1:0]
    - LSR 11010011010: A >> that same shift amount (logical)
    - MUL 10011011000: see Optional Feature
    - any other opcode: result 0
- Arithmetic wraps modulo 2^WIDTH; no carry/overflow outputs.
- Single-cycle operations: result, zero and branch_target registered on the accept edge; out_valid=1 the next cycle (latency 1).
- Hold: while out_valid && !out_ready, all outputs stay stable.
- Simultaneous pop and push in the same cycle gives full throughput (one op per cycle).
- State machine:
  - IDLE → MUL on accepting MUL (when MUL_EN is defined).
  - MUL: busy=1, in_ready=0; WIDTH/MUL_BITS cycles.
  - MUL → IDLE on the final cycle; result registered and out_valid=1 the following cycle. out_valid is already 0 on MUL entry because in_ready required it.
- Flush (synchronous, highest priority): next edge forces out_valid=0, state=IDLE, busy=0. An input presented in the same cycle is not accepted. Data registers need not clear.
- Reset mid-MUL aborts immediately; no result is produced.
- branch_target is computed for every accepted op regardless of alu_op.

Optional Feature:
Macro EXEC_MUL_EN.
- Defined: MUL runs an iterative shift-add over WIDTH/MUL_BITS cycles and produces the low WIDTH bits of A×B. Latency = WIDTH/MUL_BITS + 1 cycles from accept to out_valid.
- Undefined: the MUL state and logic are absent. MUL opcode is treated as unknown: result 0, zero=1, latency 1, busy tied 0.

Test Plan:
1. Reset low mid-stream with out_valid=1 → all outputs 0 immediately (asynchronously); in_ready=1 after release.
2. DTYPE, alu_src=1, A=16, imm=64, pc=0 → one cycle later out_valid=1, alu_result=80, zero=0, branch_target=256.
3. RTYPE SUB A=30 B=30 with out_ready=0 for 3 cycles → alu_result=0, zero=1 held stable and in_ready=0 throughout; then back-to-back ADD 10+20 → 30 on the cycle after out_ready=1.
4. CBZ, pc=16, imm=0xFFFF…FFFB (−5), read_data2=0 → branch_target=0xFFFF…FFFC (−4), zero=1.
5. EXEC_MUL_EN, WIDTH=64, MUL_BITS=1: MUL 7×9 → busy=1 for 64 cycles, out_valid on cycle 65 with result 63. Repeat with flush at cycle 10 → out_valid never asserted, busy=0 next cycle.
6. LSL A=1, B=63 → 0x8000_0000_0000_0000. LSR of that by 63 → 1. Unknown opcode 00000000000 → 0, zero=1.

Source files
------------

// File: rtl/execute_pipe.sv
// Registered LEGv8 execute stage: ALU result, zero flag and branch target behind a valid/ready output register.
// Optional iterative shift-add multiplier is built only when EXEC_MUL_EN is defined.
//
// state  | meaning
// S_IDLE | accepting operations (subject to output back-pressure)
// S_MUL  | iterating multiplier, busy=1, no new operations accepted
module execute_pipe #(
  parameter int WIDTH    = 64,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] cur_pc,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] sign_extended_output,
  input  logic [1:0]       alu_op,
  input  logic             alu_src,
  input  logic [10:0]      opcode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [1:0] ALU_DTYPE = 2'b00;
  localparam logic [1:0] ALU_CBZ   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_LSL = 11'b11010011011;
  localparam logic [10:0] OP_LSR = 11'b11010011010;
`ifdef EXEC_MUL_EN
  localparam logic [10:0] OP_MUL = 11'b10011011000;
`endif

  logic [WIDTH-1:0] r_alu_result;
  logic [WIDTH-1:0] r_branch_target;
  logic             r_zero;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_opb;
  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_branch;
  logic             w_accept;
  logic             w_idle;

  assign w_opb    = alu_src ? sign_extended_output : read_data2;
  assign w_shamt  = w_opb[SH_W-1:0];
  assign w_branch = cur_pc + (sign_extended_output << 2);
  assign w_accept = in_valid && in_ready;
  assign in_ready = w_idle && !flush && (!r_out_valid || out_ready);

  // Opcodes not listed (including MUL in the default build) yield 0.
  always_comb begin
    w_result = '0;
    case (alu_op)
      ALU_DTYPE: w_result = read_data1 + w_opb;
      ALU_CBZ:   w_result = read_data2;
      ALU_RTYPE: begin
        case (opcode)
          OP_ADD:  w_result = read_data1 + w_opb;
          OP_SUB:  w_result = read_data1 - w_opb;
          OP_AND:  w_result = read_data1 & w_opb;
          OP_ORR:  w_result = read_data1 | w_opb;
          OP_LSL:  w_result = read_data1 << w_shamt;
          OP_LSR:  w_result = read_data1 >> w_shamt;
          default: w_result = '0;
        endcase
      end
      default:   w_result = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam int              N_ITER  = WIDTH / MUL_BITS;
  localparam int              CNT_W   = $clog2(N_ITER) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_ITER - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;

  logic             w_is_mul;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_partial;
  logic [WIDTH-1:0] w_acc_next;

  assign w_is_mul   = (alu_op == ALU_RTYPE) && (opcode == OP_MUL);
  assign w_idle     = (r_state == S_IDLE);
  assign busy       = (r_state == S_MUL);
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == '0);

  // Retire MUL_BITS multiplier bits per cycle; the multiplicand is pre-shifted each step.
  always_comb begin
    w_partial = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
    end
    w_acc_next = r_acc + w_partial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state  <= S_MUL;
            r_cnt    <= CNT_MAX;
            r_acc    <= '0;
            r_mcand  <= read_data1;
            r_mplier <= w_opb;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << MUL_BITS;
          r_mplier <= r_mplier >> MUL_BITS;
          r_cnt    <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign w_idle = 1'b1;
  assign busy   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid     <= 1'b0;
      r_alu_result    <= '0;
      r_branch_target <= '0;
      r_zero          <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_branch_target <= w_branch;
`ifdef EXEC_MUL_EN
      if (w_is_mul) begin
        r_out_valid <= 1'b0;
      end else begin
        r_alu_result <= w_result;
        r_zero       <= (w_result == '0);
        r_out_valid  <= 1'b1;
      end
    end else if (w_mul_done) begin
      r_alu_result <= w_acc_next;
      r_zero       <= (w_acc_next == '0);
      r_out_valid  <= 1'b1;
`else
      r_alu_result <= w_result;
      r_zero       <= (w_result == '0);
      r_out_valid  <= 1'b1;
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign alu_result    = r_alu_result;
  assign branch_target = r_branch_target;
  assign zero          = r_zero;

endmodule

// File: tb/tb_execute_pipe.sv
// Directed scoreboard bench for execute_pipe: expected results queued on accept, compared on output handshake.
module tb_execute_pipe;
  localparam int W = 64;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_LSL = 11'b11010011011;
  localparam logic [10:0] OP_LSR = 11'b11010011010;
  localparam logic [10:0] OP_MUL = 11'b10011011000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] cur_pc;
  logic [W-1:0] read_data1;
  logic [W-1:0] read_data2;
  logic [W-1:0] sign_extended_output;
  logic [1:0]   alu_op;
  logic         alu_src;
  logic [10:0]  opcode;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] branch_target;
  logic [W-1:0] alu_result;
  logic         zero;
  logic         busy;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic [W-1:0] bt;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  execute_pipe #(.WIDTH(W), .MUL_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cur_pc(cur_pc), .read_data1(read_data1), .read_data2(read_data2),
    .sign_extended_output(sign_extended_output), .alu_op(alu_op), .alu_src(alu_src),
    .opcode(opcode), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .branch_target(branch_target), .alu_result(alu_result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] pc, input logic [W-1:0] a,
                                 input logic [W-1:0] b2, input logic [W-1:0] imm,
                                 input logic [1:0] op, input logic src, input logic [10:0] opc);
    exp_t         e;
    logic [W-1:0] b;
    logic [5:0]   sh;
    b  = src ? imm : b2;
    sh = b[5:0];
    e.res = '0;
    if (op == 2'b00) e.res = a + b;
    else if (op == 2'b01) e.res = b2;
    else if (op == 2'b10) begin
      if (opc == OP_ADD) e.res = a + b;
      else if (opc == OP_SUB) e.res = a + ~b + 64'd1;
      else if (opc == OP_AND) e.res = a & b;
      else if (opc == OP_ORR) e.res = a | b;
      else if (opc == OP_LSL) e.res = a * (64'd1 << sh);
      else if (opc == OP_LSR) e.res = a / (64'd1 << sh);
`ifdef EXEC_MUL_EN
      else if (opc == OP_MUL) e.res = a * b;
`endif
    end
    e.z  = (e.res == 64'd0);
    e.bt = pc + imm * 64'd4;
    return e;
  endfunction

  task automatic set_op(input logic [1:0] op, input logic src, input logic [10:0] opc,
                        input logic [W-1:0] pc, input logic [W-1:0] a,
                        input logic [W-1:0] b2, input logic [W-1:0] imm);
    alu_op = op; alu_src = src; opcode = opc; cur_pc = pc;
    read_data1 = a; read_data2 = b2; sign_extended_output = imm;
    in_valid = 1'b1;
  endtask

  // One clock: sample handshakes mid-low-phase, then advance to the next falling edge.
  task automatic tick();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("pop_unexpected", 64'(q.size()), 64'd1);
      else begin
        e = q.pop_front();
        chk("pop_result", alu_result, e.res);
        chk("pop_zero", 64'(zero), 64'(e.z));
        chk("pop_branch", branch_target, e.bt);
      end
    end
    if (in_valid && in_ready)
      q.push_back(model(cur_pc, read_data1, read_data2, sign_extended_output, alu_op, alu_src, opcode));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int          bc;
    logic        early;
    logic [10:0] ops[6];
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LSL, OP_LSR};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    set_op(2'b00, 1'b0, 11'd0, '0, '0, '0, '0);
    in_valid = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", alu_result, 64'd0);
    chk("rst_branch", branch_target, 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // DTYPE with immediate operand
    set_op(2'b00, 1'b1, 11'd0, 64'd0, 64'd16, 64'd0, 64'd64);
    tick();
    in_valid = 1'b0;
    chk("dtype_valid", 64'(out_valid), 64'd1);
    chk("dtype_result", alu_result, 64'd80);
    chk("dtype_branch", branch_target, 64'd256);
    tick();

    // SUB held under back-pressure, ADD waiting behind it
    out_ready = 1'b0;
    set_op(2'b10, 1'b0, OP_SUB, 64'd4, 64'd30, 64'd30, 64'd0);
    tick();
    set_op(2'b10, 1'b0, OP_ADD, 64'd8, 64'd10, 64'd20, 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_result", alu_result, 64'd0);
      chk("hold_zero", 64'(zero), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("b2b_add", alu_result, 64'd30);
    tick();

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    set_op(2'b00, 1'b0, 11'd0, 64'd100, 64'd5, 64'd6, 64'd7);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_result", alu_result, 64'd0);
    chk("async_rst_branch", branch_target, 64'd0);
    chk("async_rst_zero", 64'(zero), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // CBZ with negative branch offset
    set_op(2'b01, 1'b0, 11'd0, 64'd16, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB);
    tick();
    in_valid = 1'b0;
    chk("cbz_branch", branch_target, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("cbz_zero", 64'(zero), 64'd1);
    tick();

    // Shifts at the maximum amount, then an unknown opcode
    set_op(2'b10, 1'b0, OP_LSL, 64'd0, 64'd1, 64'd63, 64'd0);
    tick();
    chk("lsl63", alu_result, 64'h8000_0000_0000_0000);
    set_op(2'b10, 1'b0, OP_LSR, 64'd0, 64'h8000_0000_0000_0000, 64'd63, 64'd0);
    tick();
    chk("lsr63", alu_result, 64'd1);
    set_op(2'b10, 1'b0, 11'b00000000000, 64'd0, 64'd5, 64'd7, 64'd0);
    tick();
    in_valid = 1'b0;
    chk("unknown_result", alu_result, 64'd0);
    chk("unknown_zero", 64'(zero), 64'd1);
    tick();

    // Full-throughput stream of mixed operations
    for (int i = 0; i < 10; i++) begin
      set_op(2'b10, 1'($urandom_range(0, 1)), ops[$urandom_range(0, 5)],
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      #1;
      if (i > 0) chk("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    set_op(2'b11, 1'b0, 11'd0, 64'd40, 64'd9, 64'd9, 64'd3);
    tick();
    drain(10);

`ifdef EXEC_MUL_EN
    set_op(2'b10, 1'b0, OP_MUL, 64'd0, 64'd7, 64'd9, 64'd0);
    tick();
    in_valid = 1'b0;
    chk("mul_in_ready", 64'(in_ready), 64'd0);
    bc = 0; early = 1'b0;
    while (busy && bc < 200) begin
      if (out_valid) early = 1'b1;
      bc++;
      tick();
    end
    chk("mul_busy_cycles", 64'(bc), 64'd64);
    chk("mul_early_valid", 64'(early), 64'd0);
    chk("mul_valid", 64'(out_valid), 64'd1);
    chk("mul_result", alu_result, 64'd63);
    tick();

    set_op(2'b10, 1'b1, OP_MUL, 64'd0, {$urandom, $urandom}, 64'd0, {$urandom, $urandom});
    tick();
    in_valid = 1'b0;
    drain(100);

    set_op(2'b10, 1'b0, OP_MUL, 64'd0, 64'd7, 64'd9, 64'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    chk("flush_busy", 64'(busy), 64'd0);
    early = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (out_valid) early = 1'b1;
      tick();
    end
    chk("flush_no_valid", 64'(early), 64'd0);
`else
    set_op(2'b10, 1'b0, OP_MUL, 64'd0, 64'd7, 64'd9, 64'd0);
    tick();
    in_valid = 1'b0;
    chk("nomul_busy", 64'(busy), 64'd0);
    chk("nomul_valid", 64'(out_valid), 64'd1);
    chk("nomul_result", alu_result, 64'd0);
    chk("nomul_zero", 64'(zero), 64'd1);
    tick();
    bc = 0; early = 1'b0;
    // Flush while a result is pending discards it.
    out_ready = 1'b0;
    set_op(2'b00, 1'b0, 11'd0, 64'd0, 64'd1, 64'd2, 64'd0);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    q.delete();
    chk("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
`endif

    drain(10);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
